// File: rtl/processador_param.sv
// processador_param: 3-state (IDLE/EXEC/DONE) ALU with accumulator reuse and op counter.
// Define PROCESSADOR_MUL_EN to enable opcode 8 (unsigned multiply, low WIDTH bits).
module processador_param #(
   parameter int WIDTH = 8,
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [3:0]       opcode,
   input  logic [WIDTH-1:0] operand1,
   input  logic [WIDTH-1:0] operand2,
   input  logic             acc_sel,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] result,
   output logic [4:0]       flags,
   output logic             busy,
   output logic [CNT_W-1:0] op_count
);

   localparam logic [1:0] IDLE = 2'd0;
   localparam logic [1:0] EXEC = 2'd1;
   localparam logic [1:0] DONE = 2'd2;

   logic [1:0]       state_q, state_d;
   logic [3:0]       op_q, op_d;
   logic [WIDTH-1:0] a_q, a_d;
   logic [WIDTH-1:0] b_q, b_d;
   logic [WIDTH-1:0] result_q, result_d;
   logic [4:0]       flags_q, flags_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;

   logic [WIDTH-1:0] alu_r;
   logic             alu_c, alu_v, alu_e;
   logic [WIDTH:0]   sum, diff;

   assign sum  = {1'b0, a_q} + {1'b0, b_q};
   assign diff = {1'b0, a_q} - {1'b0, b_q};

`ifdef PROCESSADOR_MUL_EN
   logic [2*WIDTH-1:0] prod;
   assign prod = {{WIDTH{1'b0}}, a_q} * {{WIDTH{1'b0}}, b_q};
`endif

   always_comb begin
      alu_r = '0;
      alu_c = 1'b0;
      alu_v = 1'b0;
      alu_e = 1'b0;
      case (op_q)
         4'd0: begin
            alu_r = sum[WIDTH-1:0];
            alu_c = sum[WIDTH];
            alu_v = (a_q[WIDTH-1] == b_q[WIDTH-1]) &&
                    (alu_r[WIDTH-1] != a_q[WIDTH-1]);
         end
         4'd1: begin
            alu_r = diff[WIDTH-1:0];
            alu_c = diff[WIDTH];
            alu_v = (a_q[WIDTH-1] != b_q[WIDTH-1]) &&
                    (alu_r[WIDTH-1] != a_q[WIDTH-1]);
         end
         4'd2: alu_r = a_q & b_q;
         4'd3: alu_r = a_q | b_q;
         4'd4: alu_r = a_q ^ b_q;
         4'd5: alu_r = ~a_q;
         4'd6: begin
            alu_r = {a_q[WIDTH-2:0], 1'b0};
            alu_c = a_q[WIDTH-1];
         end
         4'd7: begin
            alu_r = {1'b0, a_q[WIDTH-1:1]};
            alu_c = a_q[0];
         end
`ifdef PROCESSADOR_MUL_EN
         4'd8: begin
            alu_r = prod[WIDTH-1:0];
            alu_c = |prod[2*WIDTH-1:WIDTH];
         end
`endif
         4'd9: alu_r = b_q;
         default: alu_e = 1'b1;
      endcase
   end

   // result_q doubles as the accumulator read back when acc_sel is set
   always_comb begin
      state_d  = state_q;
      op_d     = op_q;
      a_d      = a_q;
      b_d      = b_q;
      result_d = result_q;
      flags_d  = flags_q;
      cnt_d    = cnt_q;
      case (state_q)
         IDLE: begin
            if (in_valid) begin
               op_d    = opcode;
               b_d     = operand2;
               a_d     = acc_sel ? result_q : operand1;
               state_d = EXEC;
            end
         end
         EXEC: begin
            result_d = alu_r;
            flags_d  = {alu_e, alu_v, alu_r[WIDTH-1], alu_c, (alu_r == '0)};
            state_d  = DONE;
         end
         DONE: begin
            if (out_ready) begin
               state_d = IDLE;
               cnt_d   = cnt_q + CNT_W'(1);
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q  <= IDLE;
         op_q     <= '0;
         a_q      <= '0;
         b_q      <= '0;
         result_q <= '0;
         flags_q  <= '0;
         cnt_q    <= '0;
      end else begin
         state_q  <= state_d;
         op_q     <= op_d;
         a_q      <= a_d;
         b_q      <= b_d;
         result_q <= result_d;
         flags_q  <= flags_d;
         cnt_q    <= cnt_d;
      end
   end

   assign in_ready  = (state_q == IDLE) && !reset;
   assign out_valid = (state_q == DONE);
   assign busy      = (state_q != IDLE);
   assign result    = result_q;
   assign flags     = flags_q;
   assign op_count  = cnt_q;

endmodule

// File: tb/tb_processador_param.sv
// Scoreboard bench for processador_param (WIDTH=8, CNT_W=4 so the counter wraps).
// Expected {flags,result} come from an integer reference model.
module tb_processador_param;

   localparam int WIDTH = 8;
   localparam int CNT_W = 4;

   logic             clk = 1'b0;
   logic             reset;
   logic             in_valid;
   logic             in_ready;
   logic [3:0]       opcode;
   logic [WIDTH-1:0] operand1;
   logic [WIDTH-1:0] operand2;
   logic             acc_sel;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] result;
   logic [4:0]       flags;
   logic             busy;
   logic [CNT_W-1:0] op_count;

   int n_vec  = 0;
   int n_miss = 0;

   logic [12:0]      sb_q[$];
   logic [7:0]       acc_m = 8'h00;
   logic [CNT_W-1:0] cnt_m = '0;

   processador_param #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
      .clk(clk), .reset(reset),
      .in_valid(in_valid), .in_ready(in_ready),
      .opcode(opcode), .operand1(operand1), .operand2(operand2),
      .acc_sel(acc_sel),
      .out_valid(out_valid), .out_ready(out_ready),
      .result(result), .flags(flags), .busy(busy),
      .op_count(op_count)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout want finish");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic [31:0] got,
                      input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_miss++;
         $display("FAIL %s: got %0h want %0h", tag, got, exp);
      end
   endtask

   // returns {E,V,N,C,Z, result}
   function automatic logic [12:0] model(input logic [3:0] op,
                                         input logic [7:0] a,
                                         input logic [7:0] b);
      int ua, ub, sa, sb, r, s;
      logic c, v, e;
      logic [7:0] rr;
      ua = a; ub = b;
      sa = (ua >= 128) ? ua - 256 : ua;
      sb = (ub >= 128) ? ub - 256 : ub;
      r = 0; c = 0; v = 0; e = 0;
      case (op)
         4'd0: begin
            r = ua + ub; c = (r > 255);
            s = sa + sb; v = (s > 127) || (s < -128);
         end
         4'd1: begin
            r = ua - ub; c = (ua < ub);
            s = sa - sb; v = (s > 127) || (s < -128);
         end
         4'd2: r = ua & ub;
         4'd3: r = ua | ub;
         4'd4: r = ua ^ ub;
         4'd5: r = 255 - ua;
         4'd6: begin r = ua * 2; c = (ua >= 128); end
         4'd7: begin r = ua / 2; c = (ua % 2) == 1; end
         4'd8: begin
`ifdef PROCESSADOR_MUL_EN
            r = ua * ub; c = (r > 255);
`else
            e = 1;
`endif
         end
         4'd9: r = ub;
         default: e = 1;
      endcase
      r  = r & 255;
      rr = r[7:0];
      return {e, v, (r >= 128), c, (r == 0), rr};
   endfunction

   task automatic do_op(input logic [3:0] op, input logic [7:0] a,
                        input logic [7:0] b, input logic acc,
                        input int hold);
      logic [12:0] exp;
      logic [12:0] got;
      int lat;
      exp = model(op, acc ? acc_m : a, b);
      lat = 0;
      while (!in_ready && lat < 10) begin
         @(negedge clk);
         lat++;
      end
      chk("in_ready", in_ready, 1);
      in_valid  = 1'b1;
      opcode    = op;
      operand1  = a;
      operand2  = b;
      acc_sel   = acc;
      out_ready = (hold == 0);
      sb_q.push_back(exp);
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      opcode   = 4'($urandom);
      operand1 = 8'($urandom);
      operand2 = 8'($urandom);
      acc_sel  = 1'($urandom);
      lat = 0;
      do begin
         @(negedge clk);
         lat++;
      end while (!out_valid && lat < 8);
      chk("latency", lat, 2);
      chk("busy", busy, 1);
      got = {flags, result};
      if (sb_q.size() == 0)
         chk("sb_empty", 0, 1);
      else
         chk("result", got, sb_q.pop_front());
      acc_m = exp[7:0];
      for (int i = 0; i < hold; i++) begin
         in_valid = 1'b1;
         operand1 = 8'($urandom);
         @(negedge clk);
         chk("hold_data", {flags, result}, exp);
         chk("hold_rdy", {in_ready, out_valid}, 2'b01);
         chk("hold_cnt", op_count, cnt_m);
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
      @(negedge clk);
      cnt_m = cnt_m + 1'b1;
      chk("op_count", op_count, cnt_m);
      chk("idle", {in_ready, busy, out_valid}, 3'b100);
      chk("keep", result, exp[7:0]);
   endtask

   initial begin
      reset     = 1'b1;
      in_valid  = 1'b0;
      opcode    = 4'd0;
      operand1  = 8'd0;
      operand2  = 8'd0;
      acc_sel   = 1'b0;
      out_ready = 1'b1;
      repeat (3) @(negedge clk);
      chk("rst_rdy", in_ready, 0);
      chk("rst_state", {out_valid, busy, flags, result, op_count}, 0);
      reset = 1'b0;
      #1;
      chk("rel_rdy", in_ready, 1);

      do_op(4'd0, 8'hFF, 8'h01, 1'b0, 0);
      do_op(4'd1, 8'h05, 8'h07, 1'b0, 0);
      do_op(4'd0, 8'h7F, 8'h01, 1'b0, 0);
      do_op(4'd1, 8'h80, 8'h01, 1'b0, 0);
      do_op(4'd2, 8'hF0, 8'h3C, 1'b0, 0);
      do_op(4'd3, 8'hF0, 8'h0C, 1'b0, 0);
      do_op(4'd4, 8'hAA, 8'hFF, 1'b0, 0);
      do_op(4'd5, 8'h0F, 8'h00, 1'b0, 0);
      do_op(4'd6, 8'h81, 8'h00, 1'b0, 0);
      do_op(4'd7, 8'h81, 8'h00, 1'b0, 0);
      do_op(4'd9, 8'h12, 8'h5A, 1'b0, 0);
      do_op(4'd8, 8'h10, 8'h11, 1'b0, 0);
      do_op(4'hF, 8'h33, 8'h44, 1'b0, 0);
      do_op(4'd0, 8'h20, 8'h22, 1'b0, 5);

      // reset while the operation is in EXEC
      @(negedge clk);
      in_valid = 1'b1;
      opcode   = 4'd0;
      operand1 = 8'h01;
      operand2 = 8'h01;
      acc_sel  = 1'b0;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      chk("rexec_out", {out_valid, flags, result}, 0);
      chk("rexec_cnt", op_count, 0);
      chk("rexec_rdy", in_ready, 0);
      reset = 1'b0;
      #1;
      chk("rexec_rel", in_ready, 1);
      cnt_m = '0;
      acc_m = 8'h00;

      do_op(4'd0, 8'h03, 8'h04, 1'b0, 0);
      do_op(4'd0, 8'hEE, 8'h0A, 1'b1, 0);
      chk("acc17", result, 8'h11);
      do_op(4'd6, 8'h00, 8'h00, 1'b1, 0);
      for (int i = 0; i < 16; i++)
         do_op(4'($urandom_range(0, 15)), 8'($urandom), 8'($urandom),
               1'($urandom), (i % 5 == 0) ? 2 : 0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

endmodule
